// File: rtl/uart_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_core
//  Purpose  : FIFO-buffered UART with a 4-register CPU bus interface.
//             It provides TX/RX FIFOs, a programmable baud divider, sticky
//             overrun/framing flags and a registered level interrupt.
//  Ports    : clk            - system clock, rising edge
//             reset          - asynchronous active-low reset
//             addr/wr/rd     - register select and one-cycle access strobes
//             wdata / rdata  - 32-bit bus write / combinational read data
//             irq            - level interrupt request (registered)
//             rxd / txd      - serial input (asynchronous) / serial output
//  Options  : UART_LOOPBACK_EN - enables CTRL[2] internal TX->RX loopback
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_core #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        rxd,
  output logic        txd
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Bus registers and flags
  logic [DIV_WIDTH-1:0] div_q, div_eff;
  logic [2:0]           ctrl_q;
  logic                 ovr_q, fe_q, irq_q, tx_idle_q;
  logic                 wr_data, rd_data, wr_status, wr_ctrl, wr_div;

  // TX FIFO and shifter
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp_q, tx_rp_q;
  logic [AW:0]          tx_cnt_q;
  logic                 tx_empty, tx_full, tx_push, tx_pop, tx_tmr_end, tx_line;
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_tmr_q, tx_tmr_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 txd_q;

  // RX FIFO and sampler
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rx_wp_q, rx_rp_q;
  logic [AW:0]          rx_cnt_q;
  logic                 rx_empty, rx_full, rx_push, rx_pop, ovr_set;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_in, rx_done, rx_ferr, rx_tmr_end;
  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_tmr_q, rx_tmr_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

  logic                 unused_wdata;
  assign unused_wdata = &{1'b0, wdata};

  assign wr_data   = wr && (addr == 2'd0);
  assign rd_data   = rd && (addr == 2'd0);
  assign wr_status = wr && (addr == 2'd1);
  assign wr_ctrl   = wr && (addr == 2'd2);
  assign wr_div    = wr && (addr == 2'd3);

  assign div_eff = (div_q < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_q;

  // ---------------------------------------------------------------- TX FIFO
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  // A write into a full FIFO still lands when the shifter frees a slot that edge.
  assign tx_push  = wr_data && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= wdata[DATA_BITS-1:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
  end

  // ------------------------------------------------------------- TX shifter
  assign tx_tmr_end = (tx_tmr_q == '0);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    // The bit timer reloads only at bit boundaries, so DIV changes apply there.
    tx_tmr_d   = (tx_state_q == TX_IDLE || tx_tmr_end) ? div_eff - 1'b1 : tx_tmr_q - 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem_q[tx_rp_q];
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_tmr_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        tx_line = tx_sh_q[0];
        if (tx_tmr_end) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
          else                      tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_tmr_end) begin
          // Back-to-back characters: next start bit follows with no idle gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_mem_q[tx_rp_q];
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
    endcase
  end

  // ------------------------------------------------------------- RX sampler
  `ifdef UART_LOOPBACK_EN
  assign rx_in = ctrl_q[2] ? txd_q : rx_s2_q;
  assign txd   = txd_q || ctrl_q[2];
  `else
  assign rx_in = rx_s2_q;
  assign txd   = txd_q;
  `endif

  assign rx_tmr_end = (rx_tmr_q == '0);

  // After a framing error the sampler returns to idle; a new start needs a
  // high-to-low transition, so the line must first go high again.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    rx_tmr_d   = rx_tmr_end ? div_eff - 1'b1 : rx_tmr_q - 1'b1;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_in) begin
          rx_state_d = RX_START;
          rx_tmr_d   = (div_eff >> 1) - 1'b1;
        end
      end
      RX_START: begin
        if (rx_tmr_end) begin
          if (rx_in) rx_state_d = RX_IDLE;
          else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_tmr_end) begin
          rx_sh_d = {rx_in, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_tmr_end) begin
          rx_state_d = RX_IDLE;
          rx_done    = rx_in;
          rx_ferr    = !rx_in;
        end
      end
    endcase
  end

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_pop   = rd_data && !rx_empty;
  assign rx_push  = rx_done && (!rx_full || rx_pop);
  assign ovr_set  = rx_done && rx_full && !rx_pop;

  // ----------------------------------------------------------- state update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      ctrl_q     <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      irq_q      <= 1'b0;
      tx_idle_q  <= 1'b1;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (tx_pop && !tx_push) tx_cnt_q <= tx_cnt_q - 1'b1;
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      // Line is driven from the registered state: txd lags the FSM by a clock.
      txd_q      <= tx_line;

      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (rx_pop && !rx_push) rx_cnt_q <= rx_cnt_q - 1'b1;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_in;

      if (wr_div) div_q <= wdata[DIV_WIDTH-1:0];
      if (wr_ctrl) begin
        `ifdef UART_LOOPBACK_EN
        ctrl_q <= wdata[2:0];
        `else
        ctrl_q <= {1'b0, wdata[1:0]};
        `endif
      end
      // A new error on the same edge as a clear keeps the flag set.
      ovr_q     <= ovr_set || (ovr_q && !(wr_status && wdata[3]));
      fe_q      <= rx_ferr || (fe_q && !(wr_status && wdata[4]));
      irq_q     <= (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty);
      // Registered so TX idle is reported only once the stop bit is on the line.
      tx_idle_q <= tx_empty && (tx_state_q == TX_IDLE);
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = rx_empty ? 32'd0 : 32'(rx_mem_q[rx_rp_q]);
      2'd1: rdata = {27'd0, fe_q, ovr_q, tx_idle_q && tx_empty, tx_full, !rx_empty};
      2'd2: rdata = {29'd0, ctrl_q};
      2'd3: rdata = 32'(div_q);
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_fifo_core
//  Purpose  : Self-checking bench for uart_fifo_core (FIFO_DEPTH = 4).
//             Register vectors from a table, then hand-written serial
//             sequences for TX timing, RX overrun/framing/glitch, TX full,
//             asynchronous reset and (optionally) loopback.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_core;
  localparam int DEPTH = 4;
  localparam int DIVV  = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr  = '0;
  logic        wr    = 1'b0;
  logic        rd    = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic        rxd   = 1'b1;
  logic        txd;

  int n_total = 0;
  int n_pass  = 0;

  uart_fifo_core #(
    .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .DEFAULT_DIV(434)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
    .rdata(rdata), .irq(irq), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0]  a;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  `ifdef UART_LOOPBACK_EN
  localparam logic [31:0] CTRL7_RB = 32'h7;
  `else
  localparam logic [31:0] CTRL7_RB = 32'h3;
  `endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic read_data(output logic [31:0] d);
    addr = 2'd0;
    #1;
    d = rdata;
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(DIVV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DIVV);
    end
    rxd = stop;
    tick(DIVV);
    rxd = 1'b1;
  endtask

  // Decodes one frame from txd at DIV = 4, sampling each bit at its centre.
  task automatic capture_frame(input int limit, output logic [7:0] b,
                               output logic found, output logic stop_ok);
    b = '0; found = 1'b0; stop_ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (txd == 1'b0) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    if (!found) return;
    tick(2);
    for (int k = 0; k < 8; k++) begin
      tick(4);
      b[k] = txd;
    end
    tick(4);
    stop_ok = txd;
  endtask

  logic lb_watch = 1'b0;
  logic lb_bad   = 1'b0;
  always @(negedge clk) if (lb_watch && txd !== 1'b1) lb_bad = 1'b1;

  vec_t        vt [11];
  logic [31:0] got;
  logic [7:0]  pat;
  logic [7:0]  fb;
  logic        ffound, fstop;

  initial begin
    vt[0]  = '{2'd1, 1'b0, 32'h0,         32'h4};        // STATUS at reset
    vt[1]  = '{2'd3, 1'b0, 32'h0,         32'd434};      // DIV at reset
    vt[2]  = '{2'd2, 1'b0, 32'h0,         32'h0};        // CTRL at reset
    vt[3]  = '{2'd0, 1'b0, 32'h0,         32'h0};        // empty DATA read
    vt[4]  = '{2'd1, 1'b0, 32'h0,         32'h4};        // pointers untouched
    vt[5]  = '{2'd3, 1'b1, 32'h1,         32'h1};
    vt[6]  = '{2'd2, 1'b1, 32'h7,         CTRL7_RB};
    vt[7]  = '{2'd2, 1'b1, 32'h0,         32'h0};
    vt[8]  = '{2'd3, 1'b1, 32'hFFFF_1234, 32'h1234};     // truncated to DIV_WIDTH
    vt[9]  = '{2'd3, 1'b1, 32'd4,         32'd4};
    vt[10] = '{2'd1, 1'b1, 32'h18,        32'h4};        // clearing clear flags

    // ---------------- reset
    tick(3);
    check("rst_txd", 32'(txd), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    tick(1);
    check("post_rst_txd", 32'(txd), 32'h1);

    // ---------------- register vectors
    for (int i = 0; i < 11; i++) begin
      if (vt[i].w) bus_write(vt[i].a, vt[i].d);
      if (vt[i].a == 2'd0) read_data(got);
      else                 peek(vt[i].a, got);
      check($sformatf("vec%0d_addr%0d", i, vt[i].a), got, vt[i].exp);
    end

    // ---------------- irq is registered: one clock after its cause
    bus_write(2'd2, 32'h2);
    check("irq_tx_same", 32'(irq), 32'h0);
    tick(1);
    check("irq_tx_set", 32'(irq), 32'h1);
    bus_write(2'd2, 32'h0);
    check("irq_tx_hold", 32'(irq), 32'h1);
    tick(1);
    check("irq_tx_clr", 32'(irq), 32'h0);

    // ---------------- TX waveform, DIV = 4, byte 0x5A
    pat = 8'h5A;
    bus_write(2'd0, 32'h5A);
    check("tx_lat0", 32'(txd), 32'h1);
    peek(2'd1, got);
    check("tx_busy_stat", got & 32'h4, 32'h0);
    tick(1);
    check("tx_lat1", 32'(txd), 32'h1);
    tick(1);
    for (int i = 0; i < 40; i++) begin
      logic exp_bit;
      if (i < 4)       exp_bit = 1'b0;
      else if (i < 36) exp_bit = pat[(i - 4) / 4];
      else             exp_bit = 1'b1;
      check($sformatf("tx_wave_c%0d", i), 32'(txd), 32'(exp_bit));
      if (i == 39) begin
        peek(2'd1, got);
        check("tx_idle_early", got & 32'h4, 32'h0);
      end
      tick(1);
    end
    check("tx_after", 32'(txd), 32'h1);
    peek(2'd1, got);
    check("tx_idle_42", got & 32'h4, 32'h4);

    // ---------------- RX overrun with 5 frames into a 4-deep FIFO
    for (int i = 0; i < 5; i++) send_frame(8'(8'h11 * (i + 1)), 1'b1);
    tick(12);
    peek(2'd1, got);
    check("ovr_status", got, 32'h0D);
    for (int i = 0; i < 4; i++) begin
      read_data(got);
      check($sformatf("ovr_rd%0d", i), got, 32'(8'h11 * (i + 1)));
    end
    peek(2'd1, got);
    check("ovr_drained", got, 32'h0C);
    bus_write(2'd1, 32'h8);
    peek(2'd1, got);
    check("ovr_clear", got, 32'h04);

    // ---------------- framing error
    send_frame(8'h3C, 1'b0);
    tick(12);
    peek(2'd1, got);
    check("fe_status", got, 32'h14);
    bus_write(2'd1, 32'h10);
    peek(2'd1, got);
    check("fe_clear", got, 32'h04);

    // ---------------- 1-clock glitch, then a normal frame still works
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    peek(2'd1, got);
    check("glitch_status", got, 32'h04);
    send_frame(8'h96, 1'b1);
    tick(12);
    read_data(got);
    check("rx_after_glitch", got, 32'h96);

    // ---------------- TX full: DEPTH+2 back-to-back writes
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) begin
          bus_write(2'd0, 32'h81 + 32'(i));
          if (i == DEPTH) begin
            peek(2'd1, got);
            check("tx_full_flag", got & 32'h2, 32'h2);
          end
        end
      end
      begin
        for (int f = 0; f < DEPTH + 1; f++) begin
          capture_frame(100, fb, ffound, fstop);
          check($sformatf("txfull_found%0d", f), 32'(ffound), 32'h1);
          check($sformatf("txfull_byte%0d", f), 32'(fb), 32'h81 + 32'(f));
          check($sformatf("txfull_stop%0d", f), 32'(fstop), 32'h1);
        end
      end
    join
    capture_frame(60, fb, ffound, fstop);
    check("txfull_no_extra", 32'(ffound), 32'h0);

    // ---------------- reset during a data bit
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h00);
    tick(10);
    check("mid_frame_low", 32'(txd), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_txd", 32'(txd), 32'h1);
    tick(3);
    reset = 1'b1;
    peek(2'd1, got);
    check("rst_status", got, 32'h4);
    peek(2'd3, got);
    check("rst_div", got, 32'd434);
    capture_frame(60, fb, ffound, fstop);
    check("rst_no_frame", 32'(ffound), 32'h0);

    `ifdef UART_LOOPBACK_EN
    // ---------------- internal loopback
    bus_write(2'd3, 32'd4);
    bus_write(2'd2, 32'h5);
    lb_watch = 1'b1;
    bus_write(2'd0, 32'hA5);
    bus_write(2'd0, 32'h3C);
    bus_write(2'd0, 32'hFF);
    ffound = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (irq) begin
        ffound = 1'b1;
        break;
      end
      tick(1);
    end
    check("lb_irq", 32'(ffound), 32'h1);
    tick(100);
    lb_watch = 1'b0;
    read_data(got);
    check("lb_rd0", got, 32'hA5);
    read_data(got);
    check("lb_rd1", got, 32'h3C);
    read_data(got);
    check("lb_rd2", got, 32'hFF);
    check("lb_txd_high", 32'(lb_bad), 32'h0);
    `endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised, FIFO-buffered UART core that succeeds the single-byte UART B peripheral on the CPU register bus. It adds configurable character width, TX/RX FIFOs of configurable depth, a runtime-programmable baud divider, sticky error flags and a maskable level interrupt towards the IRQ vector logic. An internal loopback path, selected by a compile-time option, lets the system run the UART B self-test without an external `rxd`/`txd` short.

## Interface
Parameters:
- `DATA_BITS`, 8: character width; legal range 5..8.
- `FIFO_DEPTH`, 16: entries per FIFO; power of two, at least 2.
- `DIV_WIDTH`, 16: width of the divider register.
- `DEFAULT_DIV`, 434: divider value at reset, in clocks per bit.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `addr`, input, 2: register select.
- `wr`, input, 1: write strobe, one cycle per access.
- `rd`, input, 1: read strobe, one cycle per access.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: read data, combinational from `addr`; unused bits read 0.
- `irq`, output, 1: level interrupt request.
- `rxd`, input, 1: serial input; asynchronous to `clk`.
- `txd`, output, 1: serial output; idles high.

## Operation
Register map (`addr`):
- 0 DATA
  - Write: push `wdata[DATA_BITS-1:0]` into the TX FIFO. If the FIFO is full, the write is dropped.
  - Read: returns the RX FIFO head, zero-extended. The FIFO pops on the edge where `rd` is 1 and `addr` is 0. Reading an empty FIFO returns 0 and leaves the pointers unchanged.
- 1 STATUS
  - bit0: RX FIFO not empty.
  - bit1: TX FIFO full.
  - bit2: TX idle, meaning the TX FIFO is empty and the shifter is idle.
  - bit3: RX overrun, sticky.
  - bit4: framing error, sticky.
  - Writing 1 to bit3 or bit4 clears that flag.
- 2 CTRL
  - bit0: RX interrupt enable.
  - bit1: TX interrupt enable.
  - bit2: loopback.
- 3 DIV: clocks per bit. Values below 2 behave as 2.

Interrupt: `irq` = (CTRL0 and STATUS0) or (CTRL1 and TX FIFO empty).

Frame format:
- 1 start bit (0), then `DATA_BITS` data bits LSB first, then 1 stop bit (1).
- No parity.
- Each bit lasts exactly DIV clocks.

TX state machine (IDLE, START, DATA, STOP):
- IDLE with the FIFO not empty: pop the head and go to START.
- START and each DATA bit: DIV clocks each.
- STOP: DIV clocks, then return to IDLE. If the FIFO is not empty, the next start bit follows with no gap.

RX path:
- `rxd` passes through a 2-FF synchroniser.
- IDLE → START on a synchronised high-to-low edge.
- START: wait DIV/2 clocks, then resample. If the line is high, treat it as a glitch and return to IDLE.
- DATA: sample each bit at DIV-clock intervals, so sampling is at bit centre.
- STOP, sample 1: push the character into the RX FIFO. If the FIFO is full, drop the character and set overrun.
- STOP, sample 0: drop the character, set framing error, and stay in IDLE until the line has been high for one full sample.

Simultaneous events:
- TX FIFO full, with a shifter load and a DATA write on the same edge: the write is accepted and the count is unchanged.
- RX FIFO full, with a DATA read and a receive push on the same edge: both take effect and overrun is not set.
- A flag-clear write on the same edge as a new error: the flag stays set.

A DIV write during a frame takes effect at the next bit boundary.

## Timing
- Reset values:
  - `txd` = 1, `irq` = 0.
  - Both FIFOs empty, both state machines IDLE.
  - CTRL = 0, DIV = `DEFAULT_DIV`, flags = 0.
  - `rdata` follows `addr`; STATUS reads 0x4.
- A reset pulse during a frame forces `txd` high immediately (asynchronous) and discards the frame in progress and all FIFO contents.
- TX latency, on an idle UART: `txd` falls 2 clocks after the DATA write edge. The first clock is the FIFO push, the second is the shifter load.
- RX latency: STATUS0 rises at most DIV/2 + 3 clocks after the centre of the stop bit.
- `irq` is registered and changes 1 clock after its cause changes.

## Configuration
- `UART_LOOPBACK_EN`
  - Defined:
    - CTRL2 is read/write.
    - While CTRL2 = 1, the receiver takes the internal TX serial stream instead of the `rxd` pin, bypassing the synchroniser.
    - `txd` is held at 1 while CTRL2 = 1.
  - Not defined:
    - CTRL2 reads 0 and writes to it are ignored.
    - No loopback logic is synthesised.

## Test plan
- Reset: hold `reset` = 0 for 3 clocks, then release. Required: `txd` = 1, `irq` = 0, STATUS = 0x4, DIV reads 434.
- TX waveform: DIV = 4, write 0x5A. Required: `txd` is low for 4 clocks starting 2 clocks after the write edge, then bits 0,1,0,1,1,0,1,0 at 4 clocks each, then high. STATUS2 returns to 1 after 40 clocks plus 2.
- Loopback (`UART_LOOPBACK_EN`): DIV = 4, CTRL = 0x5, write 0xA5, 0x3C, 0xFF. Required: `irq` rises after the first character; three DATA reads return 0xA5, 0x3C, 0xFF; `txd` stays 1 throughout.
- RX overrun: `FIFO_DEPTH` = 4, drive 5 frames on `rxd` with no reads. Required: STATUS3 = 1 and the 4 reads return the first 4 characters. Writing 0x8 to STATUS clears STATUS3.
- Framing error and glitch:
  - Drive a frame whose stop bit is 0. Required: STATUS4 = 1 and the RX FIFO stays empty.
  - Drive a 1-clock low glitch on `rxd`. Required: nothing is received.
- TX full and reset mid-frame:
  - Write FIFO_DEPTH+2 bytes back-to-back. Required: exactly FIFO_DEPTH+1 bytes are transmitted, in order.
  - Assert `reset` during a data bit. Required: `txd` = 1 immediately and no further frames follow.
